// File: rtl/ldvio_pkg.sv
// Shared types for the set-associative load-violation predictor.
// entry_t/TAG_W describe the default geometry; the top re-derives them from its parameters.
package ldvio_pkg;

  localparam int DEF_PC_W     = 32;
  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_SETS_LOG = 8;
  localparam int DEF_CONF_W   = 2;
  localparam int TAG_W        = DEF_PC_W - DEF_SETS_LOG - DEF_OFFSET_W;

  typedef enum logic {IDLE, SWEEP} sweep_state_t;
  typedef enum logic {DECAY, CLEAR} sweep_mode_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DEF_CONF_W-1:0] conf;
  } entry_t;

endpackage

// File: rtl/ldvio_sweep_fsm.sv
// Table sweeper: free-running decay period counter plus an IDLE/SWEEP walker
// that visits one set per cycle in DECAY or CLEAR mode.
module ldvio_sweep_fsm
  import ldvio_pkg::*;
#(
  parameter int SETS_LOG         = 8,
  parameter int DECAY_EN         = 1,
  parameter int DECAY_PERIOD_LOG = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_i,
  output logic                sweep_en_o,
  output logic                sweep_mode_o,
  output logic [SETS_LOG-1:0] sweep_idx_o,
  output logic                busy_o
);

  sweep_state_t                state_q, state_d;
  sweep_mode_t                 mode_q, mode_d;
  logic [SETS_LOG-1:0]         ptr_q, ptr_d;
  logic [DECAY_PERIOD_LOG-1:0] cnt_q;
  logic                        busy_q;
  logic                        decay_trig;

  assign decay_trig = (DECAY_EN != 0) && (&cnt_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          mode_d  = CLEAR;
          ptr_d   = '0;
        end else if (decay_trig) begin
          state_d = SWEEP;
          mode_d  = DECAY;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        // A flush always wins: restart from set 0 so every set is cleared.
        if (flush_i) begin
          mode_d = CLEAR;
          ptr_d  = '0;
        end else if (ptr_q == '1) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= DECAY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_q + 1'b1;
      busy_q  <= (state_d == SWEEP);
    end
  end

  assign sweep_en_o   = (state_q == SWEEP);
  assign sweep_mode_o = mode_q;
  assign sweep_idx_o  = ptr_q;
  assign busy_o       = busy_q;

endmodule

// File: rtl/ldvio_pred_assoc.sv
// Set-associative load-violation predictor: 0-cycle per-lane lookup at dispatch,
// trained on violation recovery, with periodic confidence decay and flush sweeps.
module ldvio_pred_assoc
  import ldvio_pkg::*;
#(
  parameter int DISPATCH_WIDTH   = 4,
  parameter int PC_W             = 32,
  parameter int OFFSET_W         = 2,
  parameter int SETS_LOG         = 8,
  parameter int WAYS             = 2,
  parameter int CONF_W           = 2,
  parameter int CONF_THRESH      = 2,
  parameter int INIT_CONF        = 2,
  parameter int DECAY_EN         = 1,
  parameter int DECAY_PERIOD_LOG = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           violation_i,
  input  logic                           recover_i,
  input  logic [PC_W-1:0]                recover_pc_i,
  input  logic                           flush_i,
  input  logic [DISPATCH_WIDTH*PC_W-1:0] pc_i,
  input  logic [DISPATCH_WIDTH-1:0]      is_load_i,
  output logic [DISPATCH_WIDTH-1:0]      pred_vio_o,
  output logic                           busy_o
);

  localparam int SETS  = 2 ** SETS_LOG;
  localparam int TW    = PC_W - SETS_LOG - OFFSET_W;
  localparam int VIC_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (DECAY_PERIOD_LOG <= SETS_LOG) begin : g_bad_period
    $error("DECAY_PERIOD_LOG must exceed SETS_LOG");
  end
  if (INIT_CONF >= 2 ** CONF_W || CONF_THRESH >= 2 ** CONF_W) begin : g_bad_conf
    $error("INIT_CONF and CONF_THRESH must fit in CONF_W bits");
  end

  typedef struct packed {
    logic              valid;
    logic [TW-1:0]     tag;
    logic [CONF_W-1:0] conf;
  } ent_t;

  ent_t             tbl_q [SETS][WAYS];
  ent_t             tbl_d [SETS][WAYS];
  logic [VIC_W-1:0] vic_q [SETS];
  logic [VIC_W-1:0] vic_d [SETS];

  logic                sweep_en, sweep_mode;
  logic [SETS_LOG-1:0] sweep_idx;

  ldvio_sweep_fsm #(
    .SETS_LOG        (SETS_LOG),
    .DECAY_EN        (DECAY_EN),
    .DECAY_PERIOD_LOG(DECAY_PERIOD_LOG)
  ) u_sweep (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_i),
    .sweep_en_o  (sweep_en),
    .sweep_mode_o(sweep_mode),
    .sweep_idx_o (sweep_idx),
    .busy_o      (busy_o)
  );

  for (genvar l = 0; l < DISPATCH_WIDTH; l++) begin : g_lane
    logic [SETS_LOG-1:0] idx;
    logic [TW-1:0]       tag;
    logic                hit;
    assign idx = pc_i[l*PC_W+OFFSET_W +: SETS_LOG];
    assign tag = pc_i[l*PC_W+OFFSET_W+SETS_LOG +: TW];
    always_comb begin
      hit = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (tbl_q[idx][w].valid && tbl_q[idx][w].tag == tag &&
            tbl_q[idx][w].conf >= CONF_W'(CONF_THRESH))
          hit = 1'b1;
      end
    end
    assign pred_vio_o[l] = is_load_i[l] & hit;
  end

  logic                train;
  logic [SETS_LOG-1:0] t_idx;
  logic [TW-1:0]       t_tag;
  logic                t_hit, t_inv;
  logic [VIC_W-1:0]    t_hit_way, t_inv_way, t_way;

  assign train = violation_i & recover_i;
  assign t_idx = recover_pc_i[OFFSET_W +: SETS_LOG];
  assign t_tag = recover_pc_i[OFFSET_W+SETS_LOG +: TW];

  // Descending scan so the lowest-index invalid way ends up selected.
  always_comb begin
    t_hit     = 1'b0;
    t_hit_way = '0;
    t_inv     = 1'b0;
    t_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tbl_q[t_idx][w].valid && tbl_q[t_idx][w].tag == t_tag) begin
        t_hit     = 1'b1;
        t_hit_way = VIC_W'(w);
      end
      if (!tbl_q[t_idx][w].valid) begin
        t_inv     = 1'b1;
        t_inv_way = VIC_W'(w);
      end
    end
    t_way = t_inv ? t_inv_way : vic_q[t_idx];
  end

  always_comb begin
    tbl_d = tbl_q;
    vic_d = vic_q;
    // Training owns the set this cycle; the sweep simply passes over it.
    if (sweep_en && !(train && t_idx == sweep_idx)) begin
      for (int w = 0; w < WAYS; w++) begin
        if (sweep_mode == CLEAR || tbl_q[sweep_idx][w].conf <= CONF_W'(1)) begin
          tbl_d[sweep_idx][w].valid = 1'b0;
          tbl_d[sweep_idx][w].conf  = '0;
        end else if (tbl_q[sweep_idx][w].valid) begin
          tbl_d[sweep_idx][w].conf = tbl_q[sweep_idx][w].conf - 1'b1;
        end
      end
    end
    if (train) begin
      if (t_hit) begin
        if (tbl_q[t_idx][t_hit_way].conf != '1)
          tbl_d[t_idx][t_hit_way].conf = tbl_q[t_idx][t_hit_way].conf + 1'b1;
      end else begin
        tbl_d[t_idx][t_way].valid = 1'b1;
        tbl_d[t_idx][t_way].tag   = t_tag;
        tbl_d[t_idx][t_way].conf  = CONF_W'(INIT_CONF);
        if (!t_inv && WAYS > 1)
          vic_d[t_idx] = vic_q[t_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        vic_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) tbl_q[s][w] <= '0;
      end
    end else begin
      tbl_q <= tbl_d;
      vic_q <= vic_d;
    end
  end

endmodule

// File: tb/tb_ldvio_pred_assoc.sv
// Directed bench for ldvio_pred_assoc: lookup/train vector table, then decay,
// flush-restart, sweep/train conflict and async-reset sequences.
module tb_ldvio_pred_assoc;

  logic         clk = 1'b0;
  logic         reset;
  logic         violation_i, recover_i, flush_i;
  logic [31:0]  recover_pc_i;
  logic [127:0] pc_i;
  logic [3:0]   is_load_i;
  logic [3:0]   pred_vio_o;
  logic         busy_o;

  int checks = 0;
  int failures = 0;
  int cyc;

  ldvio_pred_assoc dut (
    .clk         (clk),
    .reset       (reset),
    .violation_i (violation_i),
    .recover_i   (recover_i),
    .recover_pc_i(recover_pc_i),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .is_load_i   (is_load_i),
    .pred_vio_o  (pred_vio_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  typedef struct {
    logic         vio;
    logic         rec;
    logic [31:0]  tpc;
    logic [127:0] pcs;
    logic [3:0]   ld;
    logic [3:0]   exp;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic lookup(input string name, input logic [127:0] pcs,
                        input logic [3:0] ld, input logic [3:0] exp);
    pc_i      = pcs;
    is_load_i = ld;
    #1;
    check(name, int'(pred_vio_o), int'(exp));
  endtask

  task automatic train(input logic [31:0] pc);
    recover_pc_i = pc;
    violation_i  = 1'b1;
    recover_i    = 1'b1;
    tick();
    violation_i  = 1'b0;
    recover_i    = 1'b0;
  endtask

  task automatic wait_rise(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (!busy_o && n < 20000) begin
      tick();
      n++;
    end
    check(name, busy_o ? cyc : -1, exp_cyc);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 1000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    violation_i  = 1'b0;
    recover_i    = 1'b0;
    flush_i      = 1'b0;
    recover_pc_i = '0;
    pc_i         = '0;
    is_load_i    = '0;

    // {vio, rec, train pc, {lane3,lane2,lane1,lane0}, is_load, expected pred}
    vt[0]  = '{0, 0, 32'h0,    {32'h1004, 32'h1004, 32'h1004, 32'h1004}, 4'b1111, 4'b0000};
    vt[1]  = '{1, 1, 32'h1004, {32'h1004, 32'h1004, 32'h1004, 32'h1004}, 4'b1111, 4'b0000};
    vt[2]  = '{0, 0, 32'h0,    {32'h1404, 32'h1004, 32'h1004, 32'h1004}, 4'b1011, 4'b0011};
    vt[3]  = '{1, 1, 32'h1404, {32'h1404, 32'h1004, 32'h1004, 32'h1004}, 4'b1011, 4'b0011};
    vt[4]  = '{1, 1, 32'h1804, {32'h1804, 32'h1404, 32'h1004, 32'h1004}, 4'b1111, 4'b0111};
    vt[5]  = '{0, 0, 32'h0,    {32'h1804, 32'h1404, 32'h1004, 32'h1004}, 4'b1111, 4'b1100};
    vt[6]  = '{1, 1, 32'h1404, {32'h2008, 32'h1804, 32'h1404, 32'h0004}, 4'b1111, 4'b0110};
    vt[7]  = '{0, 1, 32'h1004, {32'h1004, 32'h1004, 32'h1004, 32'h1004}, 4'b1111, 4'b0000};
    vt[8]  = '{0, 0, 32'h0,    {32'h1004, 32'h1004, 32'h1004, 32'h1004}, 4'b1111, 4'b0000};
    vt[9]  = '{1, 0, 32'h2008, {32'h2008, 32'h2008, 32'h2008, 32'h2008}, 4'b1111, 4'b0000};
    vt[10] = '{0, 0, 32'h0,    {32'h2008, 32'h2008, 32'h2008, 32'h2008}, 4'b1111, 4'b0000};
    vt[11] = '{1, 1, 32'h1004, {32'h1004, 32'h1804, 32'h1404, 32'h1004}, 4'b1111, 4'b0110};
    vt[12] = '{0, 0, 32'h0,    {32'h1004, 32'h1804, 32'h1404, 32'h1004}, 4'b1111, 4'b1101};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", int'(busy_o), 0);

    for (int i = 0; i < 13; i++) begin
      violation_i  = vt[i].vio;
      recover_i    = vt[i].rec;
      recover_pc_i = vt[i].tpc;
      lookup($sformatf("vec%0d", i), vt[i].pcs, vt[i].ld, vt[i].exp);
      tick();
    end
    violation_i = 1'b0;
    recover_i   = 1'b0;

    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", int'(busy_o), 1);
    wait_idle(n);
    check("flush_len", n, 256);
    lookup("flush_clear", {32'h1804, 32'h1404, 32'h1004, 32'h1004}, 4'b1111, 4'b0000);

    for (int k = 0; k < 5; k++) begin
      train(32'h1004);
      train(32'h2008);
    end
    lookup("trained", {32'h0, 32'h0, 32'h2008, 32'h1004}, 4'b0011, 4'b0011);

    wait_rise("decay1_rise", 16384);
    wait_idle(n);
    check("decay1_len", n, 256);
    lookup("decay1_pred", {32'h0, 32'h0, 32'h2008, 32'h1004}, 4'b0011, 4'b0011);

    wait_rise("decay2_rise", 32768);
    wait_idle(n);
    lookup("decay2_pred", {32'h0, 32'h0, 32'h2008, 32'h1004}, 4'b0011, 4'b0000);

    // Sweep 3: train set 0x01 during the cycle the sweep points at it.
    wait_rise("decay3_rise", 49152);
    tick();
    train(32'h1004);
    wait_idle(n);
    lookup("conflict_keep", {32'h0, 32'h0, 32'h2008, 32'h1004}, 4'b0011, 4'b0001);
    train(32'h2008);
    train(32'h0FC0);
    lookup("realloc", {32'h0, 32'h0FC0, 32'h2008, 32'h1004}, 4'b0111, 4'b0111);

    // Sweep 4: flush arrives when the decay walker is at set 0x80.
    wait_rise("decay4_rise", 65536);
    repeat (128) tick();
    lookup("pre_flush", {32'h0, 32'h0FC0, 32'h2008, 32'h1004}, 4'b0100, 4'b0100);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    wait_idle(n);
    check("restart_len", n, 256);
    lookup("post_flush", {32'h1404, 32'h0FC0, 32'h2008, 32'h1004}, 4'b1111, 4'b0000);

    train(32'h0FC0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (10) tick();
    lookup("mid_clear_pred", {32'h0, 32'h0, 32'h0, 32'h0FC0}, 4'b0001, 4'b0001);
    check("mid_clear_busy", int'(busy_o), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", int'(busy_o), 0);
    lookup("arst_pred", {32'h0, 32'h0, 32'h0, 32'h0FC0}, 4'b0001, 4'b0000);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
